// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and request bundle for the SRAM-like port arbiter.
package sram_port_arbiter_pkg;

    // Owner tag stored in the in-order response FIFO.
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // Access size encodings carried on *_size.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Request bundle: wr, size, wstrb, addr, wdata.
    localparam int unsigned REQ_W = 71;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    function automatic sram_req_t pack_req(input logic wr, input logic [1:0] size,
                                           input logic [3:0] wstrb, input logic [31:0] addr,
                                           input logic [31:0] wdata);
        sram_req_t r;
        r.wr    = wr;
        r.size  = size;
        r.wstrb = wstrb;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_owner_fifo.sv
// In-order 1-bit FIFO recording which requester owns each outstanding memory request.
module owner_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     push_owner,
    input  logic                     pop,
    output logic                     head_owner,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic          mem_q [DEPTH];
    logic          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_owner = mem_q[rd_ptr_q];

    // Next-state: pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between fetch (inst) and load/store (data) requesters.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    sram_req_t inst_bus, data_bus, mem_bus;

    logic          lock_q, lock_d;
    logic          lock_owner_q, lock_owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          arb_err_q, arb_err_d;

    logic grant, owner, accept, resp;
    logic fifo_head, fifo_full, fifo_empty;
    logic [$clog2(OUTSTANDING):0] fifo_count;

    assign inst_bus = pack_req(inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata);
    assign data_bus = pack_req(data_wr, data_size, data_wstrb, data_addr, data_wdata);

    // Grant selection: a held lock wins, else data over inst unless inst has starved.
    always_comb begin
        grant = 1'b0;
        owner = OWNER_DATA;
        if (lock_q) begin
            grant = 1'b1;
            owner = lock_owner_q;
        end else if (!fifo_full) begin
            if (data_req && inst_req) begin
                grant = 1'b1;
                owner = (starve_q == SW'(STARVE_LIMIT)) ? OWNER_INST : OWNER_DATA;
            end else if (data_req) begin
                grant = 1'b1;
                owner = OWNER_DATA;
            end else if (inst_req) begin
                grant = 1'b1;
                owner = OWNER_INST;
            end
        end
    end

    // Request, accept and response routing; everything is held at zero during reset.
    always_comb begin
        mem_req = grant & ~fifo_full & ~reset;
        mem_bus = '0;
        if (mem_req) mem_bus = (owner == OWNER_DATA) ? data_bus : inst_bus;
        mem_wr    = mem_bus.wr;
        mem_size  = mem_bus.size;
        mem_wstrb = mem_bus.wstrb;
        mem_addr  = mem_bus.addr;
        mem_wdata = mem_bus.wdata;

        accept       = mem_req & mem_addr_ok;
        inst_addr_ok = accept & (owner == OWNER_INST);
        data_addr_ok = accept & (owner == OWNER_DATA);

        resp         = mem_data_ok & ~fifo_empty & ~reset;
        inst_data_ok = resp & (fifo_head == OWNER_INST);
        data_data_ok = resp & (fifo_head == OWNER_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
        data_rdata   = data_data_ok ? mem_rdata : 32'h0;

        arb_err = arb_err_q & ~reset;
    end

    // Next-state for lock, starvation counter and sticky error.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (mem_req) begin
            lock_d       = 1'b1;
            lock_owner_d = owner;
        end

        starve_d = starve_q;
        if (!inst_req || (accept && owner == OWNER_INST)) begin
            starve_d = '0;
        end else if (accept && owner == OWNER_DATA && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end

        arb_err_d = arb_err_q | (mem_data_ok & fifo_empty);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INST;
            starve_q     <= '0;
            arb_err_q    <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
            arb_err_q    <= arb_err_d;
        end
    end

    owner_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_owner(owner),
        .pop       (resp),
        .head_owner(fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= ($clog2(OUTSTANDING) + 1)'(OUTSTANDING));

endmodule
